// File: rtl/bht_pred_ctrl_pkg.sv
// Shared types for the branch predictor controller: counter encodings,
// the in-flight queue entry and the 2-bit saturating counter update.
package bht_pred_ctrl_pkg;

    localparam int IDX_W = 10;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [1:0]       ctr;
        logic [IDX_W-1:0] ghr;
    } entry_t;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && (ctr != ST)) begin
            nxt = ctr + 2'd1;
        end else if (!taken && (ctr != SNT)) begin
            nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_pred_ctrl_if.sv
// Fetch-side prediction request and branch resolution signals.
interface bht_pred_ctrl_if #(
    parameter int PC_W = 32
);
    logic            pred_valid;
    logic [PC_W-1:0] pred_pc;
    logic            pred_ready;
    logic            pred_out_valid;
    logic            pred_taken;
    logic            res_valid;
    logic            res_taken;
    logic            mispredict;

    modport master (
        output pred_valid, pred_pc, res_valid, res_taken,
        input  pred_ready, pred_out_valid, pred_taken, mispredict
    );

    modport slave (
        input  pred_valid, pred_pc, res_valid, res_taken,
        output pred_ready, pred_out_valid, pred_taken, mispredict
    );
endinterface

// File: rtl/bht_pred_ctrl_fifo.sv
// In-order queue of in-flight branches; head is readable combinationally
// so the resolve path can compute the write-back in the same cycle.
module bp_inflight_fifo
    import bht_pred_ctrl_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  entry_t           push_data,
    output entry_t           head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    entry_t           entry_reg [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = entry_reg[rd_ptr_reg];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
                entry_reg[gi] <= push_data;
            end
        end
    end

endmodule

// File: rtl/bht_pred_ctrl.sv
// gshare prediction controller in front of a 2-bit BHT: predicts, tracks
// in-flight branches, writes back trained counters and repairs the GHR.
module bht_pred_ctrl #(
    parameter int  IDX_W = 10,
    parameter int  DEPTH = 4,
    parameter int  PC_W  = 32,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bht_pred_ctrl_if.slave       bus,
    output logic                 err,
    output logic [CNT_W-1:0]     inflight,
    output logic [IDX_W-1:0]     bht_idx,
    input  logic [1:0]           bht_rdata,
    output logic [1:0]           bht_wdata,
    output logic                 bht_wr
);
    import bht_pred_ctrl_pkg::*;

    logic [IDX_W-1:0] ghr_reg;
    logic [IDX_W-1:0] wr_idx_reg;
    logic [1:0]       bht_wdata_reg;
    logic             bht_wr_reg;
    logic             pred_out_valid_reg;
    logic             pred_taken_reg;
    logic             mispredict_reg;
    logic             err_reg;

    logic [IDX_W-1:0] idx;
    entry_t           head;
    entry_t           push_data;
    logic             full;
    logic             empty;
    logic             accept;
    logic             resolve;
    logic             mis;

    assign idx       = bus.pred_pc[IDX_W+1:2] ^ ghr_reg;
    assign push_data = '{idx: idx, ctr: bht_rdata, ghr: ghr_reg};

    // A pending write owns the shared table port, so prediction stalls.
    assign bus.pred_ready = !full && !bht_wr_reg;
    assign accept         = bus.pred_valid && bus.pred_ready;
    assign resolve        = bus.res_valid && !empty;
    assign mis            = resolve && (head.ctr[1] != bus.res_taken);

    bp_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept && !mis),
        .pop       (resolve),
        .flush     (mis),
        .push_data (push_data),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (inflight)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ghr_reg            <= '0;
            wr_idx_reg         <= '0;
            bht_wdata_reg      <= '0;
            bht_wr_reg         <= 1'b0;
            pred_out_valid_reg <= 1'b0;
            pred_taken_reg     <= 1'b0;
            mispredict_reg     <= 1'b0;
            err_reg            <= 1'b0;
        end else begin
            pred_out_valid_reg <= accept && !mis;
            mispredict_reg     <= mis;
            bht_wr_reg         <= resolve;
            err_reg            <= err_reg | (bus.res_valid && empty);
            if (accept && !mis) begin
                pred_taken_reg <= bht_rdata[1];
            end
            if (resolve) begin
                bht_wdata_reg <= sat_update(head.ctr, bus.res_taken);
                wr_idx_reg    <= head.idx;
            end
            // Repair rebuilds history from the mispredicted branch's snapshot.
            if (mis) begin
                ghr_reg <= {head.ghr[IDX_W-2:0], bus.res_taken};
            end else if (accept) begin
                ghr_reg <= {ghr_reg[IDX_W-2:0], bht_rdata[1]};
            end
        end
    end

    assign bht_idx            = bht_wr_reg ? wr_idx_reg : idx;
    assign bht_wr             = bht_wr_reg;
    assign bht_wdata          = bht_wdata_reg;
    assign bus.pred_out_valid = pred_out_valid_reg;
    assign bus.pred_taken     = pred_taken_reg;
    assign bus.mispredict     = mispredict_reg;
    assign err                = err_reg;

endmodule

// File: tb/tb_bht_pred_ctrl.sv
// Self-checking bench for bht_pred_ctrl: directed vector table, corner
// sequences and random traffic against a queue-based reference model.
module tb_bht_pred_ctrl;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       err;
    logic       bht_wr;
    logic [2:0] inflight;
    logic [9:0] bht_idx;
    logic [1:0] bht_rdata;
    logic [1:0] bht_wdata;
    logic [1:0] bht_mem [1024];

    always #5 clk = ~clk;

    bht_pred_ctrl_if #(.PC_W(32)) bus ();

    assign bht_rdata = bht_mem[bht_idx];

    bht_pred_ctrl #(.IDX_W(10), .DEPTH(DEPTH), .PC_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .err       (err),
        .inflight  (inflight),
        .bht_idx   (bht_idx),
        .bht_rdata (bht_rdata),
        .bht_wdata (bht_wdata),
        .bht_wr    (bht_wr)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference model: list of outstanding predictions plus a table copy.
    typedef struct {
        int idx;
        int ctr;
        int ghr;
    } ment_t;

    ment_t mq[$];
    int    m_tbl [1024];
    int    m_ghr, m_wr, m_wi, m_wd, m_pov, m_pt, m_mis, m_err;

    task automatic model_reset();
        mq.delete();
        m_ghr = 0; m_wr = 0; m_wi = 0; m_wd = 0;
        m_pov = 0; m_pt = 0; m_mis = 0; m_err = 0;
    endtask

    task automatic cycle(input bit pv, input logic [31:0] pc, input bit rv, input bit rt,
                         input bit rn, output int g_idx, output int g_rdy);
        int    idx, rd, acc, res, wcap, wcap_i, wcap_d;
        ment_t h;
        bus.pred_valid = pv;
        bus.pred_pc    = pc;
        bus.res_valid  = rv;
        bus.res_taken  = rt;
        rst_n          = rn;
        #1;
        g_idx = int'(bht_idx);
        g_rdy = int'(bus.pred_ready);
        idx = int'((pc >> 2) % 1024) ^ m_ghr;
        check("bht_idx", g_idx, (m_wr != 0) ? m_wi : idx);
        check("pred_ready", g_rdy, (mq.size() < DEPTH && m_wr == 0) ? 1 : 0);
        wcap   = int'(bht_wr);
        wcap_i = int'(bht_idx);
        wcap_d = int'(bht_wdata);

        rd  = m_tbl[idx];
        acc = (pv && mq.size() < DEPTH && m_wr == 0) ? 1 : 0;
        res = (rv && mq.size() > 0) ? 1 : 0;
        if (m_wr != 0) m_tbl[m_wi] = m_wd;
        if (!rn) begin
            model_reset();
        end else begin
            if (rv && mq.size() == 0) m_err = 1;
            m_wr  = res;
            m_mis = 0;
            m_pov = 0;
            if (res != 0) begin
                h     = mq.pop_front();
                m_wi  = h.idx;
                m_wd  = rt ? ((h.ctr == 3) ? 3 : h.ctr + 1) : ((h.ctr == 0) ? 0 : h.ctr - 1);
                m_mis = ((h.ctr >= 2) != rt) ? 1 : 0;
            end
            if (m_mis != 0) begin
                mq.delete();
                m_ghr = (h.ghr * 2 + int'(rt)) % 1024;
            end else if (acc != 0) begin
                mq.push_back('{idx, rd, m_ghr});
                m_pov = 1;
                m_pt  = rd / 2;
                m_ghr = (m_ghr * 2 + rd / 2) % 1024;
            end
        end

        @(posedge clk);
        #1;
        if (wcap != 0) bht_mem[wcap_i] = 2'(wcap_d);
        check("pred_out_valid", int'(bus.pred_out_valid), m_pov);
        check("mispredict", int'(bus.mispredict), m_mis);
        check("bht_wr", int'(bht_wr), m_wr);
        check("inflight", int'(inflight), mq.size());
        check("err", int'(err), m_err);
        if (m_pov != 0) check("pred_taken", int'(bus.pred_taken), m_pt);
        if (m_wr != 0)  check("bht_wdata", int'(bht_wdata), m_wd);
        $display("[TB] cyc pv=%0d pc=%h rv=%0d rt=%0d rn=%0d idx=%h pov=%0d pt=%0d wr=%0d wd=%0d mis=%0d inf=%0d err=%0d",
                 pv, pc, rv, rt, rn, g_idx, bus.pred_out_valid, bus.pred_taken, bht_wr,
                 bht_wdata, bus.mispredict, inflight, err);
    endtask

    typedef struct {
        bit          pv;
        logic [31:0] pc;
        bit          rv;
        bit          rt;
        int          e_idx, e_rdy, e_pov, e_pt, e_wr, e_wd, e_mis, e_inf;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int gi_idx, gi_rdy;
        vecs[0]  = '{1'b1, 32'h010, 1'b0, 1'b0, 'h004, 1, 1, 1, 0, 0, 0, 1};
        vecs[1]  = '{1'b0, 32'h010, 1'b1, 1'b1, 'h005, 1, 0, 0, 1, 3, 0, 0};
        vecs[2]  = '{1'b1, 32'h020, 1'b0, 1'b0, 'h004, 0, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{1'b1, 32'h020, 1'b0, 1'b0, 'h009, 1, 1, 0, 0, 0, 0, 1};
        vecs[4]  = '{1'b0, 32'h020, 1'b1, 1'b1, 'h00A, 1, 0, 0, 1, 2, 1, 0};
        vecs[5]  = '{1'b0, 32'h000, 1'b0, 1'b0, 'h009, 0, 0, 0, 0, 0, 0, 0};
        vecs[6]  = '{1'b1, 32'h01C, 1'b0, 1'b0, 'h004, 1, 1, 1, 0, 0, 0, 1};
        vecs[7]  = '{1'b0, 32'h01C, 1'b1, 1'b1, 'h000, 1, 0, 0, 1, 3, 0, 0};
        vecs[8]  = '{1'b0, 32'h01C, 1'b0, 1'b0, 'h004, 0, 0, 0, 0, 0, 0, 0};
        vecs[9]  = '{1'b1, 32'h41C, 1'b0, 1'b0, 'h100, 1, 1, 0, 0, 0, 0, 1};
        vecs[10] = '{1'b0, 32'h41C, 1'b1, 1'b0, 'h109, 1, 0, 0, 1, 0, 0, 0};
        vecs[11] = '{1'b0, 32'h41C, 1'b0, 1'b0, 'h100, 0, 0, 0, 0, 0, 0, 0};

        for (int i = 0; i < 1024; i++) begin
            bht_mem[i] = 2'b01;
            m_tbl[i]   = 1;
        end
        bht_mem['h004] = 2'b10;  m_tbl['h004] = 2;
        bht_mem['h100] = 2'b00;  m_tbl['h100] = 0;

        rst_n = 1'b0;
        bus.pred_valid = 1'b0;
        bus.pred_pc    = 32'h10;
        bus.res_valid  = 1'b0;
        bus.res_taken  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst pred_out_valid", int'(bus.pred_out_valid), 0);
        check("rst pred_taken", int'(bus.pred_taken), 0);
        check("rst mispredict", int'(bus.mispredict), 0);
        check("rst err", int'(err), 0);
        check("rst bht_wr", int'(bht_wr), 0);
        check("rst bht_wdata", int'(bht_wdata), 0);
        check("rst inflight", int'(inflight), 0);
        check("rst bht_idx", int'(bht_idx), 'h004);
        model_reset();

        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].pv, vecs[i].pc, vecs[i].rv, vecs[i].rt, 1'b1, gi_idx, gi_rdy);
            check($sformatf("vec%0d idx", i), gi_idx, vecs[i].e_idx);
            check($sformatf("vec%0d ready", i), gi_rdy, vecs[i].e_rdy);
            check($sformatf("vec%0d pov", i), int'(bus.pred_out_valid), vecs[i].e_pov);
            check($sformatf("vec%0d wr", i), int'(bht_wr), vecs[i].e_wr);
            check($sformatf("vec%0d mis", i), int'(bus.mispredict), vecs[i].e_mis);
            check($sformatf("vec%0d inflight", i), int'(inflight), vecs[i].e_inf);
            if (vecs[i].e_pov != 0) check($sformatf("vec%0d taken", i), int'(bus.pred_taken), vecs[i].e_pt);
            if (vecs[i].e_wr != 0)  check($sformatf("vec%0d wdata", i), int'(bht_wdata), vecs[i].e_wd);
        end

        // Fill the queue, then a correct resolve while full.
        for (int k = 0; k < DEPTH; k++) begin
            cycle(1'b1, 32'h3000 + 32'(k * 'h44), 1'b0, 1'b0, 1'b1, gi_idx, gi_rdy);
        end
        check("full inflight", int'(inflight), 4);
        cycle(1'b1, 32'h5000, 1'b1, 1'(mq[0].ctr / 2), 1'b1, gi_idx, gi_rdy);
        check("full ready", gi_rdy, 0);
        check("full pop wr", int'(bht_wr), 1);
        check("full pop inflight", int'(inflight), 3);
        cycle(1'b0, 32'h5000, 1'b0, 1'b0, 1'b1, gi_idx, gi_rdy);
        check("wr cycle ready", gi_rdy, 0);
        cycle(1'b0, 32'h5000, 1'b0, 1'b0, 1'b1, gi_idx, gi_rdy);
        check("after wr ready", gi_rdy, 1);

        // Head mispredicts with a same-cycle prediction request.
        cycle(1'b1, 32'h6000, 1'b1, 1'(1 - mq[0].ctr / 2), 1'b1, gi_idx, gi_rdy);
        check("flush inflight", int'(inflight), 0);
        check("flush pov", int'(bus.pred_out_valid), 0);
        check("flush mispredict", int'(bus.mispredict), 1);

        cycle(1'b0, 32'h6000, 1'b1, 1'b1, 1'b1, gi_idx, gi_rdy);
        check("empty res err", int'(err), 1);
        cycle(1'b0, 32'h6000, 1'b1, 1'b1, 1'b1, gi_idx, gi_rdy);
        check("empty res no wr", int'(bht_wr), 0);
        cycle(1'b0, 32'h6000, 1'b0, 1'b0, 1'b0, gi_idx, gi_rdy);
        check("reset err", int'(err), 0);
        check("reset inflight", int'(inflight), 0);
        cycle(1'b1, 32'h10, 1'b0, 1'b0, 1'b1, gi_idx, gi_rdy);
        check("reset ghr idx", gi_idx, 'h004);

        for (int i = 0; i < 1024; i++) begin
            bht_mem[i] = 2'($urandom_range(0, 3));
            m_tbl[i]   = int'(bht_mem[i]);
        end
        for (int n = 0; n < 800; n++) begin
            cycle(($urandom % 4) != 0, 32'($urandom), ($urandom % 3) == 0, 1'($urandom),
                  ($urandom % 100) != 0, gi_idx, gi_rdy);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
